// File: rtl/alu_gamma_pkg.sv
// rtl/alu_gamma_pkg.sv - opcodes, FSM state type and constants shared by alu_gamma and alu_gamma_muldiv
package alu_gamma_pkg;

    // Single-cycle opcodes of the slave ALU.
    localparam logic [5:0] ALU_ADD   = 6'h00;
    localparam logic [5:0] ALU_ADDU  = 6'h01;
    localparam logic [5:0] ALU_SUB   = 6'h02;
    localparam logic [5:0] ALU_SUBU  = 6'h03;
    localparam logic [5:0] ALU_SLT   = 6'h04;
    localparam logic [5:0] ALU_SLTU  = 6'h05;
    localparam logic [5:0] ALU_AND   = 6'h06;
    localparam logic [5:0] ALU_OR    = 6'h07;
    localparam logic [5:0] ALU_XOR   = 6'h08;
    localparam logic [5:0] ALU_NOR   = 6'h09;
    localparam logic [5:0] ALU_LUI   = 6'h0A;
    localparam logic [5:0] ALU_SLL   = 6'h0B;
    localparam logic [5:0] ALU_SRL   = 6'h0C;
    localparam logic [5:0] ALU_SRA   = 6'h0D;
    localparam logic [5:0] ALU_OUTA  = 6'h0E;
    localparam logic [5:0] ALU_OUTB  = 6'h0F;

    // Iterative HI/LO opcodes and the optional count-leading ops, placed above the existing codes.
    localparam logic [5:0] ALU_MULT  = 6'h10;
    localparam logic [5:0] ALU_MULTU = 6'h11;
    localparam logic [5:0] ALU_DIV   = 6'h12;
    localparam logic [5:0] ALU_DIVU  = 6'h13;
    localparam logic [5:0] ALU_CLZ   = 6'h14;
    localparam logic [5:0] ALU_CLO   = 6'h15;

    // Every bit of LO is set to this value on divide by zero.
    localparam logic DIVZ_LO_FILL = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MUL     = 2'd1,
        ST_DIV     = 2'd2,
        ST_DIV_FIX = 2'd3
    } state_t;

    function automatic logic is_mul_op(input logic [5:0] op);
        return (op == ALU_MULT) || (op == ALU_MULTU);
    endfunction

    function automatic logic is_div_op(input logic [5:0] op);
        return (op == ALU_DIV) || (op == ALU_DIVU);
    endfunction

endpackage

// File: rtl/alu_gamma_muldiv.sv
// rtl/alu_gamma_muldiv.sv - iterative shift-add multiplier and restoring divider producing HI/LO
module alu_gamma_muldiv
    import alu_gamma_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_start,
    input  logic [5:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_idle,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;

    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_dvs;
    logic               r_neg_q;
    logic               r_neg_r;

    logic               w_signed;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_prod_next;
    logic [2*WIDTH-1:0] w_prod_fixed;
    logic [WIDTH:0]     w_trial;
    logic [WIDTH-1:0]   w_quo_fixed;
    logic [WIDTH-1:0]   w_rem_fixed;

    // Signed ops work on magnitudes; the sign is reapplied at the end.
    assign w_signed = (i_op == ALU_MULT) || (i_op == ALU_DIV);
    assign w_abs_a  = (w_signed && i_a[WIDTH-1]) ? -i_a : i_a;
    assign w_abs_b  = (w_signed && i_b[WIDTH-1]) ? -i_b : i_b;

    // One radix-2 step: add multiplicand into the upper half when the low multiplier bit is set, then shift right.
    assign w_mul_sum    = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
    assign w_prod_next  = {w_mul_sum, r_prod[WIDTH-1:1]};
    assign w_prod_fixed = r_neg_q ? -w_prod_next : w_prod_next;

    // Restoring step: trial-subtract divisor from the partial remainder with the next dividend bit shifted in.
    assign w_trial     = {r_rem, r_quo[WIDTH-1]} - {1'b0, r_dvs};
    assign w_quo_fixed = r_neg_q ? -r_quo : r_quo;
    assign w_rem_fixed = r_neg_r ? -r_rem : r_rem;

    assign o_idle = (r_state == ST_IDLE);

    // State register; flush drops any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else if (i_flush) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and completion outputs.
    always_comb begin
        w_state_next = r_state;
        o_done       = 1'b0;
        o_hi         = '0;
        o_lo         = '0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_next = is_mul_op(i_op) ? ST_MUL : ST_DIV;
                end
            end
            ST_MUL: begin
                if (r_cnt == '0) begin
                    w_state_next = ST_IDLE;
                    o_done       = ~i_flush;
                    o_hi         = w_prod_fixed[2*WIDTH-1:WIDTH];
                    o_lo         = w_prod_fixed[WIDTH-1:0];
                end
            end
            ST_DIV: begin
                if (r_cnt == '0) begin
                    w_state_next = ST_DIV_FIX;
                end
            end
            ST_DIV_FIX: begin
                w_state_next = ST_IDLE;
                o_done       = ~i_flush;
                o_hi         = w_rem_fixed;
                o_lo         = w_quo_fixed;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Iteration counter: preloaded while idle, counts WIDTH-1 down to 0 while iterating.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == ST_IDLE) begin
            r_cnt <= CNT_W'(WIDTH - 1);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Operand latch on start, then one multiply or divide step per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prod  <= '0;
            r_mcand <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvs   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if ((r_state == ST_IDLE) && i_start) begin
            r_prod  <= {{WIDTH{1'b0}}, w_abs_b};
            r_mcand <= w_abs_a;
            r_rem   <= '0;
            r_quo   <= w_abs_a;
            r_dvs   <= w_abs_b;
            r_neg_q <= w_signed && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
            r_neg_r <= w_signed && i_a[WIDTH-1];
        end else if (r_state == ST_MUL) begin
            r_prod <= w_prod_next;
        end else if (r_state == ST_DIV) begin
            if (!w_trial[WIDTH]) begin
                r_rem <= w_trial[WIDTH-1:0];
                r_quo <= {r_quo[WIDTH-2:0], 1'b1};
            end else begin
                r_rem <= {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
                r_quo <= {r_quo[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/alu_gamma.sv
// rtl/alu_gamma.sv - EX-stage slave ALU with registered outputs, handshake and HI/LO mul/div (option macro ALU_GAMMA_CLZ_EN)
module alu_gamma
    import alu_gamma_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       alu_op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             hilo_we,
    output logic             exp_overflow
);

    localparam int MSB = WIDTH - 1;

    logic               r_out_valid;
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_hilo_we;
    logic               r_ovf;

    logic               w_idle;
    logic               w_accept;
    logic               w_div_zero;
    logic               w_md_start;
    logic               w_md_done;
    logic [WIDTH-1:0]   w_md_hi;
    logic [WIDTH-1:0]   w_md_lo;
    logic [SHAMT_W-1:0] w_shamt;
    logic [WIDTH-1:0]   w_sum;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_result;
    logic               w_ovf;

    assign in_ready   = w_idle;
    assign w_accept   = in_valid && w_idle && !flush;
    assign w_div_zero = is_div_op(alu_op) && (src_b == '0);
    assign w_md_start = w_accept && (is_mul_op(alu_op) || (is_div_op(alu_op) && !w_div_zero));

    assign w_shamt = src_a[SHAMT_W-1:0];
    assign w_sum   = src_a + src_b;
    assign w_diff  = src_a - src_b;

`ifdef ALU_GAMMA_CLZ_EN
    localparam int CW = $clog2(WIDTH) + 1;
    logic [CW-1:0] w_clz;
    logic [CW-1:0] w_clo;

    // Priority encoders: the most significant set (or clear) bit wins, WIDTH when none is found.
    always_comb begin
        w_clz = CW'(WIDTH);
        w_clo = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (src_a[i]) begin
                w_clz = CW'(WIDTH - 1 - i);
            end
            if (!src_a[i]) begin
                w_clo = CW'(WIDTH - 1 - i);
            end
        end
    end
`endif

    // Single-cycle result and signed-overflow detection.
    always_comb begin
        w_result = '0;
        w_ovf    = 1'b0;
        case (alu_op)
            ALU_ADD: begin
                w_result = w_sum;
                w_ovf    = (src_a[MSB] == src_b[MSB]) && (w_sum[MSB] != src_a[MSB]);
            end
            ALU_ADDU: w_result = w_sum;
            ALU_SUB: begin
                w_result = w_diff;
                w_ovf    = (src_a[MSB] != src_b[MSB]) && (w_diff[MSB] != src_a[MSB]);
            end
            ALU_SUBU: w_result = w_diff;
            ALU_SLT:  w_result = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            ALU_SLTU: w_result = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
            ALU_AND:  w_result = src_a & src_b;
            ALU_OR:   w_result = src_a | src_b;
            ALU_XOR:  w_result = src_a ^ src_b;
            ALU_NOR:  w_result = ~(src_a | src_b);
            ALU_LUI:  w_result = {src_b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            ALU_SLL:  w_result = src_b << w_shamt;
            ALU_SRL:  w_result = src_b >> w_shamt;
            ALU_SRA:  w_result = $unsigned($signed(src_b) >>> w_shamt);
            ALU_OUTA: w_result = src_a;
            ALU_OUTB: w_result = src_b;
`ifdef ALU_GAMMA_CLZ_EN
            ALU_CLZ:  w_result = WIDTH'(w_clz);
            ALU_CLO:  w_result = WIDTH'(w_clo);
`endif
            default:  w_result = '0;
        endcase
    end

    alu_gamma_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk     (clk),
        .rst     (rst),
        .i_flush (flush),
        .i_start (w_md_start),
        .i_op    (alu_op),
        .i_a     (src_a),
        .i_b     (src_b),
        .o_idle  (w_idle),
        .o_done  (w_md_done),
        .o_hi    (w_md_hi),
        .o_lo    (w_md_lo)
    );

    // Output stage: reset clears everything, flush squashes the pulse, otherwise register whichever result is ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_hilo_we   <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
            r_hilo_we   <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (w_md_done) begin
            r_out_valid <= 1'b1;
            r_result    <= '0;
            r_hi        <= w_md_hi;
            r_lo        <= w_md_lo;
            r_hilo_we   <= 1'b1;
            r_ovf       <= 1'b0;
        end else if (w_accept && !w_md_start) begin
            r_out_valid <= 1'b1;
            r_result    <= w_result;
            r_hilo_we   <= w_div_zero;
            r_ovf       <= w_ovf;
            if (w_div_zero) begin
                r_hi <= src_a;
                r_lo <= {WIDTH{DIVZ_LO_FILL}};
            end
        end else begin
            r_out_valid <= 1'b0;
            r_hilo_we   <= 1'b0;
            r_ovf       <= 1'b0;
        end
    end

    assign out_valid    = r_out_valid;
    assign result       = r_result;
    assign hi           = r_hi;
    assign lo           = r_lo;
    assign hilo_we      = r_hilo_we;
    assign exp_overflow = r_ovf;

endmodule
